time_set_controller: RTL and testbench
======================================

// Module: time_set_controller
// PURPOSE
// - Button-driven edit controller for the decade clock/calendar counter: debounces butt_change/butt_increase/butt_decrease,
//   sequences field selection, emits single-step inc/dec strobes with auto-repeat, pauses counting, drives blink mask.
// - Sits between board KEYs and the time/date counter datapath; counter applies inc/dec to field_sel with its own wrap rules.
// PARAMETERS
// - DEBOUNCE_CYC     1_000_000   cycles a raw button must be stable before accepted (20 ms @ 50 MHz)
// - REPEAT_DELAY_CYC 25_000_000  hold time before first auto-repeat strobe (0.5 s)
// - REPEAT_RATE_CYC  5_000_000   period between auto-repeat strobes (0.1 s)
// - BLINK_HALF_CYC   12_500_000  half-period of selected-field blink (0.25 s)
// - TIMEOUT_S        30          tick_1s pulses with no accepted press before edit mode exits
// PORTS
// - clk            in   1  50 MHz system clock
// - rst_n          in   1  reset, synchronous, active-low
// - sw_mode        in   1  0 = clock view, 1 = calendar view; latched on edit entry
// - tick_1s        in   1  one-cycle 1 Hz strobe from the delay divider
// - butt_change    in   1  raw KEY, active-low, asynchronous
// - butt_increase  in   1  raw KEY, active-low, asynchronous
// - butt_decrease  in   1  raw KEY, active-low, asynchronous
// - edit_active    out  1  1 while editing; counter must hold (ignore tick_1s)
// - field_sel      out  3  0 NONE,1 HOUR,2 MIN,3 SEC,4 DAY,5 MONTH,6 YEAR
// - inc_pulse      out  1  one-cycle strobe: increment field_sel by 1
// - dec_pulse      out  1  one-cycle strobe: decrement field_sel by 1
// - commit         out  1  one-cycle strobe on leaving edit mode
// - blink_mask     out  8  1 = blank digit; bit i <-> seg i (7 = leftmost)
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): state IDLE, all outputs 0, all counters 0, debounced levels = released, blink phase = visible.
// - Input path: 2-flop sync, invert to active-high; debounce counter clears on any raw change, accepts level after
//   DEBOUNCE_CYC stable cycles; press = accepted 0->1 edge, one cycle. Latency raw->press = 2 + DEBOUNCE_CYC (+1 reg) cycles.
// - FSM: IDLE -> F0 -> F1 -> F2 -> COMMIT -> IDLE, each arrow on change press; COMMIT lasts exactly 1 cycle (commit=1).
//   F0/F1/F2 = HOUR/MIN/SEC if latched mode 0, DAY/MONTH/YEAR if 1. edit_active=1 in F0..F2 and COMMIT.
// - sw_mode changes while editing are ignored until IDLE. field_sel=0 in IDLE and COMMIT.
// - inc/dec: press in F0..F2 -> pulse on same cycle as press; held >= REPEAT_DELAY_CYC -> extra pulse, then every
//   REPEAT_RATE_CYC while held. Release clears repeat counter. inc/dec presses in IDLE/COMMIT produce nothing.
// - Simultaneous events: inc and dec both held -> no pulses, repeat counters cleared; change press wins over inc/dec
//   in the same cycle (no strobe, field advances); inc_pulse and dec_pulse never both 1.
// - Timeout: idle counter +1 per tick_1s in F0..F2, cleared on any accepted press; reaching TIMEOUT_S -> COMMIT.
// - Blink: phase toggles every BLINK_HALF_CYC in F0..F2; forced to visible and timer cleared on entry to F0..F2
//   and on every inc/dec pulse. Hidden phase blanks: HOUR/DAY 8'hC0, MIN/MONTH 8'h30, SEC 8'h0C, YEAR 8'h0F; else 8'h00.
// - Counters sized $clog2(param+1); all compares exact-equality, no wrap past terminal value.
// - Reset mid-edit: immediate IDLE, no commit pulse.
// STRUCTURE
// - Package clock_pkg: field_e (3-bit enum above), edit_state_e {IDLE,F0,F1,F2,COMMIT}, blink mask constants per field.
// - Sub-module button_conditioner (sync + debounce + press edge + optional auto-repeat, params DEBOUNCE_CYC,
//   REPEAT_DELAY_CYC, REPEAT_RATE_CYC, REPEAT_EN); 3 instances, REPEAT_EN=0 for butt_change.
// - Top holds FSM, mode latch, timeout counter, blink timer, output decode.
// TESTING  (sim params: DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=20, REPEAT_RATE_CYC=5, BLINK_HALF_CYC=8, TIMEOUT_S=3)
// - Bounce butt_change low/high every 2 cycles for 20, then hold low -> exactly one press; edit_active=1, field_sel=1.
// - sw_mode=1, 4 clean change presses -> field_sel 4,5,6, then commit=1 for 1 cycle, field_sel=0, edit_active=0.
// - In F0 hold butt_increase 40 cycles after accept -> 1 + 1 (at 20) + 4 (at 25,30,35,40) = 6 inc_pulse, dec_pulse=0.
// - Hold inc and dec together in F1 -> zero pulses; inc press in IDLE -> zero pulses.
// - In F2 (clock mode) no presses, 3 tick_1s -> commit on next cycle; blink_mask alternates 8'h0C/8'h00 every 8 cycles before.
// - rst_n=0 for one clk mid-edit -> next cycle all outputs 0, no commit pulse.

Source files
------------

// File: rtl/time_set_controller_pkg.sv
// Shared types for the time/date edit controller: field codes, edit FSM states,
// per-field blink masks and the small decode helpers used by the top.
package clock_pkg;

  typedef enum logic [2:0] {
    FLD_NONE  = 3'd0,
    FLD_HOUR  = 3'd1,
    FLD_MIN   = 3'd2,
    FLD_SEC   = 3'd3,
    FLD_DAY   = 3'd4,
    FLD_MONTH = 3'd5,
    FLD_YEAR  = 3'd6
  } field_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_F0     = 3'd1,
    ST_F1     = 3'd2,
    ST_F2     = 3'd3,
    ST_COMMIT = 3'd4
  } edit_state_e;

  localparam logic [7:0] BLINK_HOUR_DAY  = 8'hC0;
  localparam logic [7:0] BLINK_MIN_MONTH = 8'h30;
  localparam logic [7:0] BLINK_SEC       = 8'h0C;
  localparam logic [7:0] BLINK_YEAR      = 8'h0F;

  function automatic logic is_edit(edit_state_e st);
    return (st == ST_F0) || (st == ST_F1) || (st == ST_F2);
  endfunction

  // Mode 0 walks the clock fields, mode 1 the calendar fields.
  function automatic field_e field_of(edit_state_e st, logic mode);
    case (st)
      ST_F0:   return mode ? FLD_DAY   : FLD_HOUR;
      ST_F1:   return mode ? FLD_MONTH : FLD_MIN;
      ST_F2:   return mode ? FLD_YEAR  : FLD_SEC;
      default: return FLD_NONE;
    endcase
  endfunction

  function automatic logic [7:0] blink_of(field_e f);
    case (f)
      FLD_HOUR, FLD_DAY:  return BLINK_HOUR_DAY;
      FLD_MIN, FLD_MONTH: return BLINK_MIN_MONTH;
      FLD_SEC:            return BLINK_SEC;
      FLD_YEAR:           return BLINK_YEAR;
      default:            return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/time_set_controller_button_conditioner.sv
// One KEY input: 2-flop sync, debounce, one-cycle press strobe and optional
// auto-repeat strobes while the debounced level stays asserted.
module button_conditioner #(
  parameter int DEBOUNCE_CYC     = 1_000_000,
  parameter int REPEAT_DELAY_CYC = 25_000_000,
  parameter int REPEAT_RATE_CYC  = 5_000_000,
  parameter bit REPEAT_EN        = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw_n,
  input  logic i_clr,
  output logic o_level,
  output logic o_press,
  output logic o_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int RW = $clog2(REPEAT_DELAY_CYC + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] RP_FIRST  = RW'(REPEAT_DELAY_CYC);
  // After a repeat strobe, restart RATE cycles short of the terminal count.
  localparam logic [RW-1:0] RP_RELOAD = RW'(REPEAT_DELAY_CYC - REPEAT_RATE_CYC + 1);

  logic [1:0]    r_sync;
  logic          r_db;
  logic          r_press;
  logic [DW-1:0] r_dcnt;
  logic [RW-1:0] r_rcnt;
  logic          w_lvl;
  logic          w_rep;

  assign w_lvl = ~r_sync[1];
  assign w_rep = REPEAT_EN && r_db && !i_clr && (r_rcnt == RP_FIRST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_db    <= 1'b0;
      r_press <= 1'b0;
      r_dcnt  <= '0;
      r_rcnt  <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_raw_n};
      r_press <= 1'b0;
      // Any return to the accepted level restarts the stability window.
      if (w_lvl == r_db) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DB_LAST) begin
        r_dcnt  <= '0;
        r_db    <= w_lvl;
        r_press <= w_lvl;
      end else begin
        r_dcnt <= r_dcnt + 1'b1;
      end
      if (!r_db || i_clr)          r_rcnt <= '0;
      else if (r_rcnt == RP_FIRST) r_rcnt <= RP_RELOAD;
      else                         r_rcnt <= r_rcnt + 1'b1;
    end
  end

  assign o_level = r_db;
  assign o_press = r_press;
  assign o_pulse = r_press | w_rep;

endmodule

// File: rtl/time_set_controller.sv
// Button-driven edit controller for the clock/calendar counter: field selection
// FSM, inc/dec strobes with auto-repeat, inactivity timeout and blink mask.
import clock_pkg::*;

module time_set_controller #(
  parameter int DEBOUNCE_CYC     = 1_000_000,
  parameter int REPEAT_DELAY_CYC = 25_000_000,
  parameter int REPEAT_RATE_CYC  = 5_000_000,
  parameter int BLINK_HALF_CYC   = 12_500_000,
  parameter int TIMEOUT_S        = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_mode,
  input  logic       tick_1s,
  input  logic       butt_change,
  input  logic       butt_increase,
  input  logic       butt_decrease,
  output logic       edit_active,
  output logic [2:0] field_sel,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       commit,
  output logic [7:0] blink_mask
);

  localparam int NUM_BTN = 3;
  localparam int BTN_CHG = 0;
  localparam int BTN_INC = 1;
  localparam int BTN_DEC = 2;
  localparam int IW = $clog2(TIMEOUT_S + 1);
  localparam int BW = $clog2(BLINK_HALF_CYC + 1);
  localparam logic [IW-1:0] TO_LAST = IW'(TIMEOUT_S - 1);
  localparam logic [IW-1:0] TO_MAX  = IW'(TIMEOUT_S);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_HALF_CYC - 1);

  edit_state_e        r_state, w_next;
  logic               r_mode;
  logic [IW-1:0]      r_idle;
  logic [BW-1:0]      r_bcnt;
  logic               r_hidden;

  logic [NUM_BTN-1:0] w_raw_n, w_clr, w_lvl, w_press, w_pulse;
  logic               w_both, w_chg, w_any_press, w_editing, w_timeout;
  logic               w_next_edit, w_enter, w_unused_chg_lvl;
  field_e             w_field;

  assign w_raw_n = {butt_decrease, butt_increase, butt_change};
  // Holding inc and dec together cancels both and restarts their repeat timers.
  assign w_both  = w_lvl[BTN_INC] & w_lvl[BTN_DEC];
  assign w_clr   = {w_both, w_both, 1'b0};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_conditioner #(
      .DEBOUNCE_CYC    (DEBOUNCE_CYC),
      .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
      .REPEAT_RATE_CYC (REPEAT_RATE_CYC),
      .REPEAT_EN       (i != BTN_CHG)
    ) u_btn (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_raw_n(w_raw_n[i]),
      .i_clr  (w_clr[i]),
      .o_level(w_lvl[i]),
      .o_press(w_press[i]),
      .o_pulse(w_pulse[i])
    );
  end

  assign w_unused_chg_lvl = w_lvl[BTN_CHG];
  assign w_chg       = w_pulse[BTN_CHG];
  assign w_any_press = |w_press;
  assign w_editing   = is_edit(r_state);
  assign w_field     = field_of(r_state, r_mode);
  assign w_timeout   = w_editing && tick_1s && !w_any_press && (r_idle == TO_LAST);
  assign w_next_edit = is_edit(w_next);
  assign w_enter     = w_next_edit && (w_next != r_state);

  always_comb begin
    w_next      = r_state;
    edit_active = 1'b0;
    field_sel   = 3'd0;
    commit      = 1'b0;
    inc_pulse   = 1'b0;
    dec_pulse   = 1'b0;
    blink_mask  = 8'h00;
    case (r_state)
      ST_IDLE:   if (w_chg) w_next = ST_F0;
      ST_F0:     if (w_chg) w_next = ST_F1; else if (w_timeout) w_next = ST_COMMIT;
      ST_F1:     if (w_chg) w_next = ST_F2; else if (w_timeout) w_next = ST_COMMIT;
      ST_F2:     if (w_chg || w_timeout) w_next = ST_COMMIT;
      ST_COMMIT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    edit_active = w_editing || (r_state == ST_COMMIT);
    field_sel   = w_field;
    commit      = (r_state == ST_COMMIT);
    // A change press in the same cycle takes priority over inc/dec.
    inc_pulse   = w_editing && w_pulse[BTN_INC] && !w_both && !w_chg;
    dec_pulse   = w_editing && w_pulse[BTN_DEC] && !w_both && !w_chg;
    if (w_editing && r_hidden) blink_mask = blink_of(w_field);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_mode   <= 1'b0;
      r_idle   <= '0;
      r_bcnt   <= '0;
      r_hidden <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_chg) r_mode <= sw_mode;
      if (!w_editing || w_any_press)          r_idle <= '0;
      else if (tick_1s && r_idle != TO_MAX)   r_idle <= r_idle + 1'b1;
      // Show the digits immediately on field entry and after every step.
      if (!w_next_edit || w_enter || inc_pulse || dec_pulse) begin
        r_bcnt   <= '0;
        r_hidden <= 1'b0;
      end else if (r_bcnt == BL_LAST) begin
        r_bcnt   <= '0;
        r_hidden <= ~r_hidden;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench for time_set_controller: directed corner sequences, a
// vector table of button actions and randomized actions against a field-level model.
module tb_time_set_controller;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 5;
  localparam int BH = 8;
  localparam int TO = 3;

  logic       clk = 1'b0, rst_n = 1'b0, sw_mode = 1'b0, tick_1s = 1'b0;
  logic       b_chg = 1'b1, b_inc = 1'b1, b_dec = 1'b1;
  logic       edit_active, inc_pulse, dec_pulse, commit;
  logic [2:0] field_sel;
  logic [7:0] blink_mask;

  int n_chk = 0, n_fail = 0;
  int n_inc = 0, n_dec = 0, n_cmt = 0, n_both = 0;

  typedef struct {
    int mode; int btn; int h;
    int e_inc; int e_dec; int e_fld; int e_edit; int e_cmt;
  } vec_t;
  vec_t tbl[12];

  time_set_controller #(
    .DEBOUNCE_CYC(D), .REPEAT_DELAY_CYC(RD), .REPEAT_RATE_CYC(RR),
    .BLINK_HALF_CYC(BH), .TIMEOUT_S(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_mode(sw_mode), .tick_1s(tick_1s),
    .butt_change(b_chg), .butt_increase(b_inc), .butt_decrease(b_dec),
    .edit_active(edit_active), .field_sel(field_sel), .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse), .commit(commit), .blink_mask(blink_mask)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (inc_pulse) n_inc++;
    if (dec_pulse) n_dec++;
    if (commit) n_cmt++;
    if (inc_pulse && dec_pulse) n_both++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // btn: 0 change, 1 increase, 2 decrease, 3 increase+decrease together
  task automatic press(input int btn, input int h, input int gap);
    case (btn)
      0: b_chg = 1'b0;
      1: b_inc = 1'b0;
      2: b_dec = 1'b0;
      default: begin b_inc = 1'b0; b_dec = 1'b0; end
    endcase
    cyc(h);
    b_chg = 1'b1; b_inc = 1'b1; b_dec = 1'b1;
    cyc(gap);
  endtask

  task automatic tick_once();
    tick_1s = 1'b1; cyc(1); tick_1s = 1'b0; cyc(3);
  endtask

  // Strobes for a hold of h cycles: one on accept, then at 20, 25, 30 ... cycles held after it.
  function automatic int rep_pulses(input int h);
    int held = h - 1;
    int n = 1;
    if (held >= RD) n += 1 + (held - RD) / RR;
    return n;
  endfunction

  initial begin
    int bi, bd, bc, prev, run, toggles, bad_val, bad_run, v;
    bit first;
    int m_edit, m_fld, m_mode, m_idle, btn, h, nt;

    tbl[0]  = '{1, 0, 10, 0, 0, 4, 1, 0};
    tbl[1]  = '{1, 1, 41, 6, 0, 4, 1, 0};
    tbl[2]  = '{0, 2, 10, 0, 1, 4, 1, 0};
    tbl[3]  = '{0, 0, 10, 0, 0, 5, 1, 0};
    tbl[4]  = '{1, 2, 26, 0, 3, 5, 1, 0};
    tbl[5]  = '{1, 0, 10, 0, 0, 6, 1, 0};
    tbl[6]  = '{1, 1, 21, 2, 0, 6, 1, 0};
    tbl[7]  = '{1, 0, 10, 0, 0, 0, 0, 1};
    tbl[8]  = '{1, 1, 30, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 10, 0, 0, 1, 1, 0};
    tbl[10] = '{0, 0, 10, 0, 0, 2, 1, 0};
    tbl[11] = '{0, 3, 40, 0, 0, 2, 1, 0};

    cyc(3);
    chk("reset_outputs", {edit_active, field_sel, inc_pulse, dec_pulse, commit, blink_mask}, 0);
    rst_n = 1'b1;
    cyc(2);
    chk("post_reset_outputs", {edit_active, field_sel, inc_pulse, dec_pulse, commit, blink_mask}, 0);

    for (int i = 0; i < 10; i++) begin
      b_chg = (i % 2) != 0;
      cyc(2);
    end
    chk("bounce_no_accept", edit_active, 0);
    b_chg = 1'b0; cyc(12); b_chg = 1'b1; cyc(12);
    chk("bounce_edit", edit_active, 1);
    chk("bounce_field", field_sel, 1);

    press(0, 10, 12);
    press(0, 10, 12);
    chk("f2_field", field_sel, 3);

    prev = blink_mask; run = 1; toggles = 0; bad_val = 0; bad_run = 0; first = 1'b1;
    for (int i = 0; i < 48; i++) begin
      cyc(1);
      v = blink_mask;
      if (v != 0 && v != 8'h0C) bad_val++;
      if (v == prev) run++;
      else begin
        if (!first && run != BH) bad_run++;
        first = 1'b0; toggles++; run = 1; prev = v;
      end
    end
    chk("blink_values", bad_val, 0);
    chk("blink_run_len", bad_run, 0);
    chk("blink_toggles", toggles >= 4, 1);

    bc = n_cmt;
    tick_once(); tick_once();
    chk("timeout_hold_edit", edit_active, 1);
    chk("timeout_hold_field", field_sel, 3);
    tick_1s = 1'b1; cyc(1); tick_1s = 1'b0;
    chk("timeout_commit", commit, 1);
    chk("timeout_commit_field", field_sel, 0);
    cyc(1);
    chk("timeout_exit_edit", edit_active, 0);
    chk("timeout_commit_count", n_cmt - bc, 1);

    for (int i = 0; i < 12; i++) begin
      sw_mode = (tbl[i].mode != 0);
      bi = n_inc; bd = n_dec; bc = n_cmt;
      press(tbl[i].btn, tbl[i].h, 12);
      chk($sformatf("vec%0d_inc", i), n_inc - bi, tbl[i].e_inc);
      chk($sformatf("vec%0d_dec", i), n_dec - bd, tbl[i].e_dec);
      chk($sformatf("vec%0d_field", i), field_sel, tbl[i].e_fld);
      chk($sformatf("vec%0d_edit", i), edit_active, tbl[i].e_edit);
      chk($sformatf("vec%0d_commit", i), n_cmt - bc, tbl[i].e_cmt);
    end

    bc = n_cmt;
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
    chk("midreset_outputs", {edit_active, field_sel, inc_pulse, dec_pulse, commit, blink_mask}, 0);
    cyc(4);
    chk("midreset_no_commit", n_cmt - bc, 0);
    chk("midreset_idle", edit_active, 0);

    m_edit = 0; m_fld = 0; m_mode = 0; m_idle = 0;
    for (int a = 0; a < 24; a++) begin
      v = $urandom_range(0, 9);
      btn = (v < 4) ? 0 : (v < 7) ? 1 : 2;
      h = $urandom_range(8, 45);
      sw_mode = $urandom_range(0, 1);
      bi = n_inc; bd = n_dec; bc = n_cmt;
      v = 0; nt = 0;
      if (btn == 0) begin
        if (m_edit == 0) begin m_edit = 1; m_fld = 0; m_mode = sw_mode; end
        else if (m_fld < 2) m_fld++;
        else begin m_edit = 0; v = 1; end
        m_idle = 0;
      end else if (m_edit != 0) begin
        nt = rep_pulses(h);
        m_idle = 0;
      end
      press(btn, h, 12);
      for (int t = $urandom_range(0, 3); t > 0; t--) begin
        tick_once();
        if (m_edit != 0) begin
          m_idle++;
          if (m_idle == TO) begin m_edit = 0; m_idle = 0; v++; end
        end
      end
      chk($sformatf("rnd%0d_inc", a), n_inc - bi, (btn == 1) ? nt : 0);
      chk($sformatf("rnd%0d_dec", a), n_dec - bd, (btn == 2) ? nt : 0);
      chk($sformatf("rnd%0d_commit", a), n_cmt - bc, v);
      chk($sformatf("rnd%0d_edit", a), edit_active, m_edit);
      chk($sformatf("rnd%0d_field", a), field_sel,
          (m_edit == 0) ? 0 : (m_mode != 0 ? 4 + m_fld : 1 + m_fld));
    end

    chk("never_both_pulses", n_both, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
